pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, meaning program counter width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, meaning the PC value loaded on reset.
REQ-003 The block SHALL have parameter STACK_DEPTH, default 8, meaning the number of return-stack entries (power of two, 2..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port pc_en, input, 1 bit: advance or modify the PC this cycle.
REQ-007 The block SHALL have port pc_ld, input, 1 bit: when qualified by pc_en, load target instead of incrementing.
REQ-008 The block SHALL have port target, input, 16 bits: jump target register value; bits [WIDTH-1:0] used.
REQ-009 The block SHALL have port push, input, 1 bit: call; save link value on the return stack.
REQ-010 The block SHALL have port pop, input, 1 bit: return; restore PC from the return stack.
REQ-011 The block SHALL have port pc, output, WIDTH bits: current instruction address (registered).
REQ-012 The block SHALL have port pc_ins, output, WIDTH bits: link value, pc+1 modulo 2^WIDTH (combinational from pc).
REQ-013 The block SHALL have port stack_empty, output, 1 bit: return stack holds zero entries.
REQ-014 The block SHALL have port stack_full, output, 1 bit: return stack holds STACK_DEPTH entries.
REQ-015 The block SHALL have port stack_err, output, 1 bit: sticky overflow/underflow/conflict indicator.

Function
REQ-016 With pc_en=0, pc, stack contents and stack pointer SHALL hold; push, pop and pc_ld are ignored.
REQ-017 With pc_en=1, pc_ld=0, push=0, pop=0, pc SHALL become pc+1, wrapping all-ones to 0.
REQ-018 With pc_en=1, pc_ld=1, pop=0, pc SHALL become target[WIDTH-1:0] on the next edge (one-cycle latency).
REQ-019 With pc_en=1, pc_ld=1, push=1, pop=0 and stack not full, the block SHALL push pc_ins and load target in the same edge.
REQ-020 push with pc_ld=0 SHALL be ignored (no push, no error); pc follows REQ-017.
REQ-021 With pc_en=1, pop=1, push=0 and stack not empty, pc SHALL become the top entry and the entry SHALL be removed; pop takes priority over pc_ld.
REQ-022 Push when full SHALL discard the push, set stack_err, and still load target.
REQ-023 Pop when empty SHALL leave the stack unchanged, set stack_err, and pc SHALL become pc+1.
REQ-024 push=1 and pop=1 with pc_en=1 SHALL set stack_err, leave the stack unchanged, and pc SHALL follow REQ-017/REQ-018 per pc_ld.
REQ-025 stack_err SHALL remain 1 until reset.
REQ-026 stack_empty and stack_full SHALL be derived from the registered stack pointer and reflect the post-edge state.

Reset
REQ-027 When reset=1 at a rising edge, pc SHALL become RESET_VECTOR, the stack pointer 0, stack_err 0, stack_empty 1, stack_full 0, overriding all other inputs.
REQ-028 Stack entry contents need not be cleared on reset.
REQ-029 Reset asserted mid-call or mid-return SHALL discard the in-flight operation entirely.

Configuration
REQ-030 Macro PC_UNIT_RETURN_STACK_EN defined: the return stack and REQ-019 to REQ-025 SHALL be implemented.
REQ-031 Macro PC_UNIT_RETURN_STACK_EN undefined: no stack storage; push and pop ignored (pop does not override pc_ld); stack_empty tied 1, stack_full 0, stack_err 0.

Verification
REQ-032 Reset then 5 cycles pc_en=1 -> pc sequence 0,1,2,3,4,5; pc_ins = pc+1 each cycle.
REQ-033 pc=0x3FF, pc_en=1 -> pc=0x000, pc_ins=0x001; pc_en=0 for 3 cycles -> pc holds.
REQ-034 pc=0x010, pc_en=1, pc_ld=1, push=1, target=0xF123 -> pc=0x123, stack_empty=0; then pc_en=1, pop=1 -> pc=0x011, stack_empty=1.
REQ-035 9 consecutive calls at depth 8 -> stack_full=1 after 8th; 9th sets stack_err, pc=target; 8 pops return in LIFO order.
REQ-036 Pop on empty stack at pc=0x020 -> pc=0x021, stack_err=1 until reset; reset -> stack_err=0, pc=RESET_VECTOR.
REQ-037 Build without PC_UNIT_RETURN_STACK_EN: pc_ld=1, pop=1, target=0x0040 -> pc=0x040, stack_empty=1, stack_err=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with optional call/return stack; the stack is built only when
// PC_UNIT_RETURN_STACK_EN is defined, otherwise push/pop are ignored.
module pc_unit #(
  parameter int          WIDTH        = 10,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int          STACK_DEPTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic             pc_ld,
  input  logic [15:0]      target,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_ins,
  output logic             stack_empty,
  output logic             stack_full,
  output logic             stack_err
);

  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] link;
  logic [WIDTH-1:0] tgt;

  assign link   = pc_q + WIDTH'(1);
  assign tgt    = target[WIDTH-1:0];
  assign pc     = pc_q;
  assign pc_ins = link;

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

`ifdef PC_UNIT_RETURN_STACK_EN

  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int PW = $clog2(STACK_DEPTH + 1);

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic             err_q, err_d;
  logic             wr_en;
  logic             empty, full;
  logic [AW-1:0]    wr_idx, top_idx;
  logic             unused_target;

  assign unused_target = ^target;

  // sp_q counts occupied entries, so the next free slot is sp_q and the top is sp_q-1
  assign wr_idx  = sp_q[AW-1:0];
  assign top_idx = AW'(sp_q - PW'(1));
  assign empty   = (sp_q == '0);
  assign full    = (sp_q == PW'(STACK_DEPTH));

  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    wr_en = 1'b0;
    if (pc_en) begin
      if (push && pop) begin
        err_d = 1'b1;
        pc_d  = pc_ld ? tgt : link;
      end else if (pop) begin
        if (empty) begin
          err_d = 1'b1;
          pc_d  = link;
        end else begin
          pc_d = stack_mem[top_idx];
          sp_d = sp_q - PW'(1);
        end
      end else if (pc_ld) begin
        pc_d = tgt;
        if (push) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            sp_d  = sp_q + PW'(1);
          end
        end
      end else begin
        pc_d = link;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entry contents survive reset; only the pointer is cleared
  always_ff @(posedge clk) begin
    if (wr_en && !reset) stack_mem[wr_idx] <= link;
  end

  assign stack_empty = empty;
  assign stack_full  = full;
  assign stack_err   = err_q;

`else

  logic unused_inputs;

  assign unused_inputs = ^{push, pop, target};

  always_comb begin
    pc_d = pc_q;
    if (pc_en) pc_d = pc_ld ? tgt : link;
  end

  assign stack_empty = 1'b1;
  assign stack_full  = 1'b0;
  assign stack_err   = 1'b0;

`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand sequences for
// stack corner cases, and randomized traffic against a queue-based model.
module tb_pc_unit;
  localparam int W     = 10;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset, pc_en, pc_ld, push, pop;
  logic [15:0]   target;
  logic [W-1:0]  pc, pc_ins;
  logic          stack_empty, stack_full, stack_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(W), .RESET_VECTOR(0), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_ld(pc_ld), .target(target),
    .push(push), .pop(pop), .pc(pc), .pc_ins(pc_ins),
    .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
  );

  typedef struct {
    logic        rst, en, ld, psh, pp;
    logic [15:0] tgt;
    int          epc;
    logic        eempty, efull, eerr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic en, logic ld, logic psh, logic pp,
                              logic [15:0] tgt, int epc, logic eempty, logic efull, logic eerr);
    vec_t v;
    v = '{rst, en, ld, psh, pp, tgt, epc, eempty, efull, eerr};
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic ld, input logic psh,
                       input logic pp, input logic [15:0] tgt);
    reset = rst; pc_en = en; pc_ld = ld; push = psh; pop = pp; target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int epc, input logic eempty,
                             input logic efull, input logic eerr);
    chk({tag, ".pc"}, int'(pc), epc);
    chk({tag, ".pc_ins"}, int'(pc_ins), (epc + 1) & MASK);
    chk({tag, ".empty"}, int'(stack_empty), int'(eempty));
    chk({tag, ".full"}, int'(stack_full), int'(efull));
    chk({tag, ".err"}, int'(stack_err), int'(eerr));
  endtask

  // Behavioural model: PC as an integer, return stack as a queue
  int m_pc;
  int m_q[$];
  bit m_err;

  task automatic model_step(input logic rst, input logic en, input logic ld, input logic psh,
                            input logic pp, input logic [15:0] tgt);
    int nxt = (m_pc + 1) & MASK;
    int t   = int'(tgt) & MASK;
    if (rst) begin
      m_pc = 0; m_q.delete(); m_err = 0;
    end else if (en) begin
`ifdef PC_UNIT_RETURN_STACK_EN
      if (psh && pp) begin
        m_err = 1; m_pc = ld ? t : nxt;
      end else if (pp) begin
        if (m_q.size() == 0) begin m_err = 1; m_pc = nxt; end
        else m_pc = m_q.pop_back();
      end else if (ld) begin
        if (psh) begin
          if (m_q.size() == DEPTH) m_err = 1;
          else m_q.push_back(nxt);
        end
        m_pc = t;
      end else m_pc = nxt;
`else
      m_pc = ld ? t : nxt;
`endif
    end
  endtask

  initial begin
    reset = 1'b1; pc_en = 1'b0; pc_ld = 1'b0; push = 1'b0; pop = 1'b0; target = '0;

    // ---- directed vector table ----
    vq.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 'h000, 1, 0, 0));
    for (int i = 1; i <= 5; i++) vq.push_back(mk(0, 1, 0, 0, 0, 16'h0000, i, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 'h005, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 16'hF3FF, 'h3FF, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 'h000, 1, 0, 0));
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 'h000, 1, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 16'h0055, 'h000, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 16'h0040, 'h040, 1, 0, 0));
`ifdef PC_UNIT_RETURN_STACK_EN
    vq.push_back(mk(0, 1, 1, 0, 0, 16'h0010, 'h010, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 16'hF123, 'h123, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 1, 16'h0200, 'h011, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 0, 16'h0000, 'h012, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 16'h0020, 'h020, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 'h021, 1, 0, 1));
    vq.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 'h022, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 'h022, 1, 0, 1));
    vq.push_back(mk(1, 1, 1, 1, 0, 16'h0123, 'h000, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 16'h0050, 'h050, 1, 0, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 'h000, 1, 0, 0));
`else
    vq.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 'h041, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 1, 16'h0040, 'h040, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 16'h0100, 'h100, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 1, 16'h0000, 'h101, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 16'h0000, 'h102, 1, 0, 0));
`endif
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].en, vq[i].ld, vq[i].psh, vq[i].pp, vq[i].tgt);
      $display("vec %0d: rst=%0b en=%0b ld=%0b push=%0b pop=%0b tgt=%h -> pc=%h", i,
               vq[i].rst, vq[i].en, vq[i].ld, vq[i].psh, vq[i].pp, vq[i].tgt, pc);
      check_state($sformatf("vec%0d", i), vq[i].epc, vq[i].eempty, vq[i].efull, vq[i].eerr);
    end

`ifdef PC_UNIT_RETURN_STACK_EN
    // ---- nine nested calls at depth 8, then eight LIFO returns ----
    drive(1, 0, 0, 0, 0, 16'h0000);
    check_state("call.rst", 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 1, 1, 0, 16'(16'h0100 + i * 16'h10));
      $display("call %0d: pc=%h full=%0b err=%0b", i, pc, stack_full, stack_err);
      check_state($sformatf("call%0d", i), 'h100 + i * 'h10, 1'b0, i >= 7, i == 8);
    end
    for (int k = 0; k < 8; k++) begin
      int c = 7 - k;
      int exp_link = (c == 0) ? 1 : ('h100 + (c - 1) * 'h10 + 1);
      drive(0, 1, 0, 0, 1, 16'h0000);
      $display("ret %0d: pc=%h empty=%0b", k, pc, stack_empty);
      check_state($sformatf("ret%0d", k), exp_link, k == 7, 1'b0, 1'b1);
    end
    drive(1, 0, 0, 0, 0, 16'h0000);
    check_state("ret.rst", 0, 1, 0, 0);
`endif

    // ---- randomized traffic against the model ----
    m_pc = 0; m_q.delete(); m_err = 0;
    drive(1, 0, 0, 0, 0, 16'h0000);
    for (int n = 0; n < 3000; n++) begin
      logic rst, en, ld, psh, pp;
      logic [15:0] tgt;
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 2) == 0);
      psh = ($urandom_range(0, 2) == 0);
      pp  = ($urandom_range(0, 3) == 0);
      tgt = 16'($urandom);
      drive(rst, en, ld, psh, pp, tgt);
      model_step(rst, en, ld, psh, pp, tgt);
      check_state($sformatf("rnd%0d", n), m_pc, m_q.size() == 0, m_q.size() == DEPTH, m_err);
      if (n_fail > 20) break;
    end
    $display("random phase done: %0d checks so far", n_chk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
